// File: rtl/product_accumulator_if.sv
// Handshake bundle between a product source, the accumulator and the sum consumer.
// The slave modport is the accumulator's view; master is the surrounding logic.
interface product_accumulator_if #(
  parameter int IN_W  = 7,
  parameter int ACC_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums frames of N unsigned products into an ACC_W-bit result with a sticky wrap flag,
// then holds the result on a valid/ready output until it is taken.
module product_accumulator #(
  parameter int IN_W  = 7,
  parameter int ACC_W = 10,
  parameter int N     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  product_accumulator_if.slave bus
);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [ACC_W-1:0] sum_reg, sum_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_sticky_reg, ovf_sticky_next;
  logic             ovf_reg, ovf_next;
  logic             accept;
  logic [ACC_W:0]   sum_ext;

  // Ready is a pure function of state, so out_ready never reaches in_ready.
  assign bus.in_ready  = (state_reg == ACC);
  assign bus.out_valid = (state_reg == HOLD);
  assign bus.out_sum   = sum_reg;
  assign bus.out_ovf   = ovf_reg;

  assign accept  = bus.in_valid && (state_reg == ACC);
  assign sum_ext = {1'b0, acc_reg} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};

  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    cnt_next        = cnt_reg;
    ovf_sticky_next = ovf_sticky_reg;
    sum_next        = sum_reg;
    ovf_next        = ovf_reg;

    if (clear) begin
      // Abort drops partial and pending frames but leaves the last result visible.
      state_next      = ACC;
      acc_next        = '0;
      cnt_next        = '0;
      ovf_sticky_next = 1'b0;
    end else begin
      case (state_reg)
        ACC: begin
          if (accept) begin
            if (cnt_reg == LAST) begin
              sum_next        = sum_ext[ACC_W-1:0];
              ovf_next        = ovf_sticky_reg | sum_ext[ACC_W];
              acc_next        = '0;
              cnt_next        = '0;
              ovf_sticky_next = 1'b0;
              state_next      = HOLD;
            end else begin
              acc_next        = sum_ext[ACC_W-1:0];
              ovf_sticky_next = ovf_sticky_reg | sum_ext[ACC_W];
              cnt_next        = cnt_reg + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_next = ACC;
          end
        end
        default: state_next = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ACC;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      ovf_sticky_reg <= 1'b0;
      sum_reg        <= '0;
      ovf_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      ovf_sticky_reg <= ovf_sticky_next;
      sum_reg        <= sum_next;
      ovf_reg        <= ovf_next;
    end
  end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 4-bit constant multiplier; consumes its 7-bit products.
- Sums a frame of N products into a wider accumulator and presents the frame sum with a valid/ready handshake.
- Input side has a valid/ready handshake so upstream sources can stall; output side holds the result until it is taken.

Parameters:
- IN_W, 7, width of incoming product (matches multiplier output).
- ACC_W, 10, accumulator/result width; must be >= IN_W.
- N, 8, products per frame; legal range 1..256.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame abort, highest priority after reset.
- in_valid  input  1  product present on in_data.
- in_ready  output  1  block can accept a product this cycle.
- in_data  input  IN_W  unsigned product.
- out_valid  output  1  frame sum valid.
- out_ready  input  1  downstream takes the sum this cycle.
- out_sum  output  ACC_W  frame sum, modulo 2^ACC_W.
- out_ovf  output  1  frame sum wrapped (carry out of ACC_W at any add in the frame).

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: state=ACC, acc=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0, ovf_sticky=0. in_ready is 1 immediately after deassertion.
- There are two states, ACC and HOLD.
- ACC state:
  - in_ready=1 and out_valid=0.
  - Accept occurs when in_valid & in_ready.
  - On accept, the sum is acc + zero-extended in_data, computed with 1 extra bit.
  - acc takes the low ACC_W bits of that sum. ovf_sticky |= carry. cnt increments.
  - On the accept with cnt==N-1, out_sum is registered as the final sum and out_ovf as the final sticky value. out_valid<=1, acc<=0, cnt<=0, ovf_sticky<=0, and the state goes to HOLD.
  - Latency: out_valid rises the cycle after the Nth accept.
  - Cycles with in_valid=0 leave acc and cnt unchanged. Gaps are allowed.
- HOLD state:
  - in_ready=0, and in_data is ignored.
  - out_sum and out_ovf are stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid<=0 and the state returns to ACC. in_ready=1 from the next cycle.
  - out_sum and out_ovf keep their last values after the handshake.
- N=1: every accepted product goes straight to HOLD, so throughput is 1 product per 2 cycles at best.
- Maximum sustained rate is N products per N+1 cycles, because the block does not accept in the cycle of the output handshake.
- clear=1 at a clock edge:
  - acc, cnt and ovf_sticky go to 0, out_valid goes to 0, and the state goes to ACC.
  - Any in-flight product in that cycle is discarded.
  - A pending HOLD result is dropped.
  - out_sum and out_ovf keep their last values.
- Reset mid-frame: all partial state is lost and the next frame starts counting from 0.
- in_ready depends only on state; there is no combinational path from out_ready to in_ready.

Test Plan:
- 8 accepts of in_data=21 on back-to-back cycles, out_ready=1 -> out_valid=1 the cycle after the 8th accept, out_sum=168, out_ovf=0, out_valid for exactly 1 cycle, in_ready low for that cycle only.
- Products 0,3,6,...,21 with random 0-3 cycle in_valid gaps -> out_sum=84; acc unaffected by idle cycles.
- ACC_W=9, 8 x in_data=127 -> out_sum=1016 mod 512=504, out_ovf=1; the next frame of 8 x 1 gives out_sum=8, out_ovf=0 (sticky cleared).
- Frame completes with out_ready held 0 for 5 cycles -> out_sum and out_valid stable throughout, in_ready=0, in_valid pulses ignored; out_ready=1 releases, and the next frame sum is unaffected by the ignored inputs.
- clear asserted after 3 accepts of 45, then 8 accepts of 10 -> out_sum=80; clear during HOLD -> out_valid drops the next cycle with no handshake.
- rst_n pulsed low asynchronously (mid-cycle) after 5 accepts -> outputs zero immediately; after release, 8 accepts of 2 -> out_sum=16.
